// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin WISHBONE arbiter that shares one slave port among NUM_MASTERS
// masters. A master owns the slave for its whole CYC cycle. Owners are always separated by
// one dead IDLE cycle.
// Optional watchdog abort of hung slave cycles: define WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ADR_W          = 6,
    parameter int unsigned DAT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned SEL_W = DAT_W / 8,
    localparam int unsigned GNT_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                         clk,
    input  logic                         wb_rst_i,
    input  logic [NUM_MASTERS-1:0]       m_cyc_i,
    input  logic [NUM_MASTERS-1:0]       m_stb_i,
    input  logic [NUM_MASTERS-1:0]       m_we_i,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_sel_i,
    input  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i,
    output logic [DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]       m_ack_o,
    output logic [NUM_MASTERS-1:0]       m_err_o,
    output logic [NUM_MASTERS-1:0]       m_rty_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic [SEL_W-1:0]             s_sel_o,
    output logic [ADR_W-1:0]             s_adr_o,
    output logic [DAT_W-1:0]             s_dat_o,
    input  logic [DAT_W-1:0]             s_dat_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,
    input  logic                         s_rty_i,
    output logic [GNT_W-1:0]             grant_o,
    output logic                         busy_o
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_bus_arbiter: NUM_MASTERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StAbort
    } state_e;

    state_e           r_state, w_state_next;
    logic [GNT_W-1:0] r_grant, w_grant_next;
    logic [GNT_W-1:0] r_rr, w_rr_next;
    logic             w_found;
    logic [GNT_W-1:0] w_winner;
    logic [GNT_W-1:0] w_cand;

    // Fields of the current owner, selected by the registered grant
    logic             w_own_cyc;
    logic             w_own_stb;
    logic             w_own_we;
    logic [SEL_W-1:0] w_own_sel;
    logic [ADR_W-1:0] w_own_adr;
    logic [DAT_W-1:0] w_own_dat;

    assign w_own_cyc = m_cyc_i[r_grant];
    assign w_own_stb = m_stb_i[r_grant];
    assign w_own_we  = m_we_i[r_grant];
    assign w_own_sel = m_sel_i[r_grant*SEL_W +: SEL_W];
    assign w_own_adr = m_adr_i[r_grant*ADR_W +: ADR_W];
    assign w_own_dat = m_dat_i[r_grant*DAT_W +: DAT_W];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wdog, w_wdog_next;
    logic            r_abort_first, w_abort_first_next;
    logic            w_term;

    assign w_term = s_ack_i | s_err_i | s_rty_i;
`endif

    // Round-robin scan: first requester strictly after the last winner, wrapping around
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = GNT_W'((32'(r_rr) + i) % NUM_MASTERS);
            if (!w_found && m_cyc_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Next-state logic: grant in IDLE, hold while owner keeps CYC, optional watchdog abort
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr;
`ifdef WB_ARB_TIMEOUT_EN
        w_wdog_next        = '0;
        w_abort_first_next = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_grant_next = w_winner;
                    w_rr_next    = w_winner;
                    w_state_next = StOwn;
                end
            end
            StOwn: begin
                if (!w_own_cyc) begin
                    w_state_next = StIdle;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_own_stb && !w_term) begin
                    if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_next       = StAbort;
                        w_abort_first_next = 1'b1;
                    end else begin
                        w_wdog_next = r_wdog + 1'b1;
                    end
                end
`endif
            end
            StAbort: begin
                if (!w_own_cyc) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State registers; rr starts at the last master so master 0 wins first after reset
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_rr    <= GNT_W'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_abort_first <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_rr    <= w_rr_next;
`ifdef WB_ARB_TIMEOUT_EN
            r_wdog        <= w_wdog_next;
            r_abort_first <= w_abort_first_next;
`endif
        end
    end

    // Slave mux and termination routing; everything idles low unless a master owns the bus
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (r_state == StOwn) begin
            s_cyc_o          = w_own_cyc;
            s_stb_o          = w_own_stb;
            s_we_o           = w_own_we;
            s_sel_o          = w_own_sel;
            s_adr_o          = w_own_adr;
            s_dat_o          = w_own_dat;
            m_ack_o[r_grant] = s_ack_i;
            m_err_o[r_grant] = s_err_i;
            m_rty_o[r_grant] = s_rty_i;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (r_state == StAbort) begin
            m_err_o[r_grant] = r_abort_first;
        end
`endif
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;
    assign busy_o  = (r_state != StIdle);

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin WISHBONE arbiter that shares one slave port (the peripheral register-file WISHBONE interface) among NUM_MASTERS bus masters.
- Sits between the masters (CPU, DMA, crypto engine) and the peripheral wrapper. It grants the slave to one master for a whole CYC_O cycle, muxes that master's signals onto the slave port and routes ACK/ERR/RTY back to it only.
- An optional watchdog aborts slave cycles that hang.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- ADR_W, 6, address width.
- DAT_W, 32, data width. SEL width is DAT_W/8.
- TIMEOUT_CYCLES, 64, watchdog limit in clocks. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- m_cyc_i  in  NUM_MASTERS  per-master CYC
- m_stb_i  in  NUM_MASTERS  per-master STB
- m_we_i  in  NUM_MASTERS  per-master WE
- m_sel_i  in  NUM_MASTERS*DAT_W/8  packed SEL, master k at [k*4+:4]
- m_adr_i  in  NUM_MASTERS*ADR_W  packed address
- m_dat_i  in  NUM_MASTERS*DAT_W  packed write data
- m_dat_o  out  DAT_W  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ACK
- m_err_o  out  NUM_MASTERS  per-master ERR
- m_rty_o  out  NUM_MASTERS  per-master RTY
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave CYC/STB/WE
- s_sel_o  out  DAT_W/8  slave SEL
- s_adr_o  out  ADR_W  slave address
- s_dat_o  out  DAT_W  slave write data
- s_dat_i  in  DAT_W  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination
- grant_o  out  $clog2(NUM_MASTERS)  index of current owner
- busy_o  out  1  slave owned by a master

Behaviour:
- Reset (async, wb_rst_i=1):
  - state=IDLE; rr pointer = NUM_MASTERS-1, so master 0 has top priority first.
  - grant_o=0, busy_o=0, all s_* outputs 0, m_ack_o/m_err_o/m_rty_o=0.
  - Watchdog counter=0.
  - Reset mid-transaction drops s_cyc_o immediately; no termination is sent to the master.
- States:
  - IDLE: no owner. If any m_cyc_i is set, pick the first requester scanning from rr+1 upward, with wrap-around. Register grant_o and set rr to the winner. Next state OWN.
  - OWN: the winner is muxed onto the slave. busy_o=1.
  - ABORT: exists only with WB_ARB_TIMEOUT_EN (see Optional Feature).
- Grant latency: request seen in IDLE at cycle t; s_cyc_o asserts at t+1 (one-cycle arbitration bubble).
- OWN datapath (combinational from registered grant g):
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g]; s_we_o, s_sel_o, s_adr_o, s_dat_o = master g's fields.
  - m_ack_o[g] = s_ack_i, m_err_o[g] = s_err_i, m_rty_o[g] = s_rty_i. All other bits are 0.
  - m_dat_o = s_dat_i at all times.
- Ownership is held while m_cyc_i[g]=1, including idle STB gaps and multi-beat bursts; other requests wait.
- When m_cyc_i[g] falls, go to IDLE on that edge. s_cyc_o is 0 in the same cycle because it is combinational.
- The next owner is chosen in the following IDLE cycle, so there is always one dead cycle between owners.
- Simultaneous requests: round-robin only; no fixed priority except the reset pointer.
- A request that drops CYC while waiting is simply not granted. No state is stored per waiting master.
- Outside OWN: all s_* outputs are 0 and all m_ack/err/rty are 0.
- Termination signals asserted by the slave while no master is owner are ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in OWN while s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0. It clears on any termination, when STB is low, and in IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the next state is ABORT.
  - ABORT: s_cyc_o=s_stb_o=0. m_err_o[g]=1 for exactly the first ABORT cycle, then 0.
  - The arbiter stays in ABORT until m_cyc_i[g]=0, then goes to IDLE. busy_o=1 during ABORT.
- Not defined: no counter, no ABORT state. A hung slave holds the bus indefinitely.

Test Plan:
- Single master: master 2 does a write, CYC/STB held, slave ACKs 4 clocks later.
  - s_cyc_o rises 1 clock after m_cyc_i[2] with grant_o=2.
  - s_adr_o/s_dat_o match master 2.
  - m_ack_o=4'b0100 for one cycle; the other bits stay 0.
- Simultaneous requests: masters 0 and 3 assert CYC in the same cycle after reset.
  - Master 0 is granted first.
  - After it drops CYC: one IDLE cycle, then grant_o=3.
- Fairness: all 4 masters request continuously with single-beat cycles.
  - Grant order is 0,1,2,3,0,1…; no master is granted twice before the others.
- Hold across burst: master 1 does 3 back-to-back STB beats with CYC held and one STB-low gap; master 0 requests throughout.
  - grant_o stays 1 until master 1's CYC falls, then master 0 is granted.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never ACKs.
  - After 8 STB clocks, s_cyc_o=0 and m_err_o[g] pulses for 1 clock.
  - Arbiter returns to IDLE after the master drops CYC.
- Reset mid-transaction: wb_rst_i asserted while master 1 owns the bus.
  - All s_* outputs and busy_o go 0 asynchronously.
  - After reset release, master 0 wins if masters 0 and 1 both request.
